gpu_draw_sched: RTL
===================

Name: gpu_draw_sched

Overview:
- Sequences framebuffer access for the GPU datapath.
- Accepts CLEAR and DRAW (XOR-sprite) commands from the CPU, executes them as row-wise read-modify-write on a single-port 32x64 framebuffer RAM, and returns VF collision status.
- Arbitrates the same RAM port with a scanout/display reader, so the display can fetch rows while a draw is in flight.

Parameters:
- FB_ROWS, 32, framebuffer rows (row address width = 5)
- FB_COLS, 64, framebuffer row width in bits; bit 63 = column 0

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  1  0 = DRAW, 1 = CLEAR
- cmd_x  in  8  sprite column (VX)
- cmd_y  in  8  sprite row (VY)
- cmd_height  in  4  sprite rows (N), 0..15
- cmd_sprite  in  120  sprite bytes; row i = bits [119-8i -: 8]
- done  out  1  one-cycle pulse on command completion
- vf_out  out  8  collision flag of last DRAW: 8'h01 or 8'h00
- scan_req  in  1  scanout row read request
- scan_row  in  5  row to read
- scan_grant  out  1  pulse; scan_row sampled this cycle
- scan_valid  out  1  pulse, cycle after scan_grant
- scan_data  out  64  row data, fb_rdata when scan_valid, else 0
- fb_addr  out  5  RAM address
- fb_we  out  1  RAM write enable
- fb_wdata  out  64  RAM write data
- fb_rdata  in  64  RAM read data, 1-cycle synchronous read latency

Behaviour:
- States: IDLE, CLR, RD, WR, SCAN, DONE. fb_* outputs are combinational from state/registers and all 0 in IDLE/DONE.
- Reset (asynchronous): state=IDLE; done=0, vf_out=0, scan_grant=0, scan_valid=0, fb_we=0. Any in-flight command is dropped with no done. fb_we falls immediately because it is decoded from state.
- cmd_ready = (state==IDLE) && !scan_req. scan_req has priority in IDLE.
- On accept, latch all cmd_* fields:
  - x0 = cmd_x mod 64
  - y0 = cmd_y mod 32
  - row counter i = 0
  - collision = 0
- CLEAR:
  - CLR for 32 cycles, rows 0..31 in order.
  - fb_we=1, fb_wdata=0, fb_addr=row.
  - Then DONE. vf_out is unchanged.
- DRAW, per row:
  - RD: fb_addr = y0+i, fb_we=0.
  - WR: fb_addr = y0+i, fb_we=1, fb_wdata = fb_rdata ^ mask, where mask = ({byte_i,56'b0} >> x0) truncated to 64 bits. Pixels past column 63 are clipped, with no wrap.
  - In WR: collision |= |(fb_rdata & mask).
  - After WR: i++. If i==height or y0+i>=32 (bottom clip, 6-bit compare), go to DONE; else go to RD.
- height==0: accept -> DONE next cycle, vf_out=8'h00, no RAM access.
- DONE: done=1 for one cycle. On DRAW, vf_out = {7'b0,collision}, held until the next DRAW's DONE. Next state is IDLE.
- Latency, unclipped DRAW with no scan interleave:
  - accept at T, rows at T+1..T+2h, done at T+2h+1, cmd_ready at T+2h+2 earliest.
  - CLEAR: done at T+33.
- SCAN: fb_addr=scan_row, scan_grant=1 (one cycle). Next cycle scan_valid=1 and scan_data=fb_rdata; this data cycle may overlap the following state.
- Arbitration inside a command:
  - After a CLR write or DRAW WR, if scan_req is high and the previous slot was not SCAN, insert one SCAN slot, then resume.
  - This guarantees at most one scan per row step and no starvation of either side.
  - No scan is inserted between a command's final row and DONE.
  - In IDLE, scan_req high -> SCAN, repeatable back-to-back. A pending cmd waits.
- Simultaneous scan_req and cmd_valid in IDLE: scan is served first; cmd accepted when scan_req drops.

Test Plan:
1. Preload fb all ones; CLEAR accepted at T -> 32 writes of 0 to rows 0..31 in order; done at T+33; vf_out unchanged.
2. Zeroed fb; DRAW x=0 y=0 h=1 byte0=8'hF0 -> row0=64'hF000_0000_0000_0000, vf_out=8'h00, done at T+3. Repeat the same DRAW -> row0=0, vf_out=8'h01.
3. Clip: DRAW x=60 y=30 h=4, all bytes 8'hFF -> rows 30,31 = 64'h0000_0000_0000_000F; rows 0,1 untouched; done at T+5.
4. Wrap: DRAW x=70 y=40 h=1 byte0=8'h80 -> row 8 = 64'h0200_0000_0000_0000 (column 6).
5. Arbitration: scan_req held high from T+1 during DRAW h=3 with scan_row=8 -> scan slots after rows 0 and 1 only; scan_valid data equals row 8; draw results correct; done at T+9.
6. rst_n low during WR of row 1 of DRAW h=4 -> fb_we=0 immediately, no done pulse, vf_out=0; after release cmd_ready=1 and a new CLEAR completes normally.

Source files
------------

// File: rtl/gpu_draw_sched.sv
// Framebuffer access sequencer: runs CLEAR / XOR-sprite DRAW commands as row-wise
// read-modify-write on a single-port RAM and interleaves scanout row reads.
module gpu_draw_sched #(
   parameter int FB_ROWS = 32,
   parameter int FB_COLS = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // Handshake: a transfer happens on a rising edge where valid && ready;
   // valid holds its payload until then. Scan requests use req/grant instead.
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_op,
   input  logic [7:0]                 cmd_x,
   input  logic [7:0]                 cmd_y,
   input  logic [3:0]                 cmd_height,
   input  logic [119:0]               cmd_sprite,
   output logic                       done,
   output logic [7:0]                 vf_out,
   input  logic                       scan_req,
   input  logic [$clog2(FB_ROWS)-1:0] scan_row,
   output logic                       scan_grant,
   output logic                       scan_valid,
   output logic [FB_COLS-1:0]         scan_data,
   output logic [$clog2(FB_ROWS)-1:0] fb_addr,
   output logic                       fb_we,
   output logic [FB_COLS-1:0]         fb_wdata,
   input  logic [FB_COLS-1:0]         fb_rdata,
   output logic [2:0]                 o_dbg_state
);

   localparam int ROW_W = $clog2(FB_ROWS);
   localparam int COL_W = $clog2(FB_COLS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_RD   = 3'd2,
      S_WR   = 3'd3,
      S_SCAN = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   state_t               r_ret;
   logic                 r_prev_scan;
   logic                 r_scan_valid;
   logic [COL_W-1:0]     r_x0;
   logic [ROW_W-1:0]     r_y0;
   logic [3:0]           r_height;
   logic [119:0]         r_sprite;
   logic [ROW_W-1:0]     r_i;
   logic                 r_coll;
   logic [7:0]           r_vf;

   logic                 w_accept;
   logic [7:0]           w_byte;
   logic [FB_COLS-1:0]   w_mask;
   logic                 w_hit;
   logic [ROW_W-1:0]     w_row_addr;
   logic [ROW_W:0]       w_i_next;
   logic [ROW_W:0]       w_y_next;
   logic                 w_draw_last;
   logic                 w_clr_last;
   logic                 w_unused_hi;

   assign w_unused_hi = ^{cmd_x[7:COL_W], cmd_y[7:ROW_W]};

   // Sprite bytes are consumed from the top; the register shifts one byte per row.
   assign w_byte      = r_sprite[119:112];
   assign w_mask      = {w_byte, {(FB_COLS-8){1'b0}}} >> r_x0;
   assign w_hit       = |(fb_rdata & w_mask);
   assign w_row_addr  = r_y0 + r_i;
   assign w_i_next    = {1'b0, r_i} + 1'b1;
   assign w_y_next    = {1'b0, r_y0} + w_i_next;
   assign w_draw_last = (w_i_next == (ROW_W+1)'(r_height)) ||
                        (w_y_next >= (ROW_W+1)'(FB_ROWS));
   assign w_clr_last  = (r_i == ROW_W'(FB_ROWS-1));
   assign w_accept    = cmd_valid && cmd_ready;

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      fb_addr     = '0;
      fb_we       = 1'b0;
      fb_wdata    = '0;
      scan_grant  = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = !scan_req;
            if (scan_req) begin
               w_state_nxt = S_SCAN;
            end else if (cmd_valid) begin
               if (cmd_op)
                  w_state_nxt = S_CLR;
               else if (cmd_height == 4'd0)
                  w_state_nxt = S_DONE;
               else
                  w_state_nxt = S_RD;
            end
         end
         S_CLR: begin
            fb_addr = r_i;
            fb_we   = 1'b1;
            if (w_clr_last)
               w_state_nxt = S_DONE;
            else if (scan_req && !r_prev_scan)
               w_state_nxt = S_SCAN;
            else
               w_state_nxt = S_CLR;
         end
         S_RD: begin
            fb_addr     = w_row_addr;
            w_state_nxt = S_WR;
         end
         S_WR: begin
            fb_addr  = w_row_addr;
            fb_we    = 1'b1;
            fb_wdata = fb_rdata ^ w_mask;
            if (w_draw_last)
               w_state_nxt = S_DONE;
            else if (scan_req && !r_prev_scan)
               w_state_nxt = S_SCAN;
            else
               w_state_nxt = S_RD;
         end
         S_SCAN: begin
            fb_addr    = scan_row;
            scan_grant = 1'b1;
            // Outside a command, scans may run back-to-back.
            if ((r_ret == S_IDLE) && scan_req)
               w_state_nxt = S_SCAN;
            else
               w_state_nxt = r_ret;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ret        <= S_IDLE;
         r_prev_scan  <= 1'b0;
         r_scan_valid <= 1'b0;
         r_x0         <= '0;
         r_y0         <= '0;
         r_height     <= '0;
         r_sprite     <= '0;
         r_i          <= '0;
         r_coll       <= 1'b0;
         r_vf         <= 8'h00;
      end else begin
         r_state      <= w_state_nxt;
         r_prev_scan  <= (r_state == S_SCAN);
         r_scan_valid <= (r_state == S_SCAN);
         if ((w_state_nxt == S_SCAN) && (r_state != S_SCAN))
            r_ret <= (r_state == S_WR) ? S_RD : r_state;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x0     <= cmd_x[COL_W-1:0];
                  r_y0     <= cmd_y[ROW_W-1:0];
                  r_height <= cmd_height;
                  r_sprite <= cmd_sprite;
                  r_i      <= '0;
                  r_coll   <= 1'b0;
                  if (!cmd_op && (cmd_height == 4'd0))
                     r_vf <= 8'h00;
               end
            end
            S_CLR: r_i <= r_i + 1'b1;
            S_WR: begin
               r_coll   <= r_coll | w_hit;
               r_i      <= w_i_next[ROW_W-1:0];
               r_sprite <= r_sprite << 8;
               if (w_draw_last)
                  r_vf <= {7'b0, r_coll | w_hit};
            end
            default: ;
         endcase
      end
   end

   assign vf_out      = r_vf;
   assign scan_valid  = r_scan_valid;
   assign scan_data   = r_scan_valid ? fb_rdata : '0;
   assign o_dbg_state = r_state;

endmodule
